// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot_acc accumulator and its result FIFO.
package dot_acc_pkg;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned LEN_W  = 8;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(255);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Per-result bookkeeping; the ACC_W-wide sum travels alongside it.
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             ovf;
    } res_meta_t;

endpackage

// File: rtl/dot_acc_fifo.sv
// Small synchronous result FIFO holding {sum, len, ovf} records; head is read
// straight from the storage registers.
module dot_acc_fifo
    import dot_acc_pkg::*;
#(
    parameter int unsigned SUM_W = 24,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SUM_W-1:0] push_sum,
    input  res_meta_t        push_meta,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [SUM_W-1:0] head_sum,
    output res_meta_t        head_meta
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [SUM_W-1:0] r_sum  [DEPTH];
    res_meta_t        r_meta [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sum[i]  <= '0;
                r_meta[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_sum[r_wr_ptr]  <= push_sum;
                r_meta[r_wr_ptr] <= push_meta;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(w_pop);
        end
    end

    assign count     = r_count;
    assign head_sum  = r_sum[r_rd_ptr];
    assign head_meta = r_meta[r_rd_ptr];

endmodule

// File: rtl/dot_acc.sv
// Signed dot-product accumulator behind a 2-edge multiplier, with credit-based
// input flow control. Define DOT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic [LEN_W-1:0]         out_len,
    output logic                     out_ovf
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CR_W  = CNT_W + 1;

    logic                    r_d1_valid, r_d1_last, r_d2_valid, r_d2_last;
    state_t                  r_state, w_state_nxt;
    logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
    logic [LEN_W-1:0]        r_len, w_len_nxt, w_len_inc;
    logic                    r_ovf, w_ovf_nxt;

    logic                    w_accept;
    logic [CNT_W-1:0]        w_count;
    logic [CR_W-1:0]         w_lasts;
    logic signed [ACC_W-1:0] w_prod_ext, w_sum_raw, w_sum;
    logic                    w_add_ovf;
    logic                    w_push;
    logic [ACC_W-1:0]        w_push_sum;
    res_meta_t               w_push_meta;
    logic [ACC_W-1:0]        w_head_sum;
    res_meta_t               w_head_meta;

    // Lasts still in the delay line already own a FIFO slot.
    assign w_lasts  = CR_W'(r_d1_last) + CR_W'(r_d2_last);
    assign in_ready = (CR_W'(w_count) + w_lasts) < CR_W'(DEPTH);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d1_valid <= 1'b0;
            r_d1_last  <= 1'b0;
            r_d2_valid <= 1'b0;
            r_d2_last  <= 1'b0;
        end else begin
            r_d1_valid <= w_accept;
            r_d1_last  <= w_accept && in_last;
            r_d2_valid <= r_d1_valid;
            r_d2_last  <= r_d1_last;
        end
    end

    assign w_prod_ext = ACC_W'(prod);
    assign w_sum_raw  = r_acc + w_prod_ext;
    assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum_raw[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_len_inc  = (r_len == LEN_MAX) ? LEN_MAX : r_len + LEN_W'(1);

`ifdef DOT_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign w_sum = w_add_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum_raw;
`else
    assign w_sum = w_sum_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_len_nxt         = r_len;
        w_ovf_nxt         = r_ovf;
        w_push            = 1'b0;
        w_push_sum        = w_sum;
        w_push_meta.len   = w_len_inc;
        w_push_meta.ovf   = r_ovf | w_add_ovf;
        case (r_state)
            IDLE: begin
                if (r_d2_valid) begin
                    if (r_d2_last) begin
                        w_push          = 1'b1;
                        w_push_sum      = w_prod_ext;
                        w_push_meta.len = LEN_W'(1);
                        w_push_meta.ovf = 1'b0;
                    end else begin
                        w_acc_nxt   = w_prod_ext;
                        w_len_nxt   = LEN_W'(1);
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (r_d2_valid) begin
                    if (r_d2_last) begin
                        w_push      = 1'b1;
                        w_acc_nxt   = '0;
                        w_len_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_len_nxt = w_len_inc;
                        w_ovf_nxt = r_ovf | w_add_ovf;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    dot_acc_fifo #(
        .SUM_W (ACC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_sum  (w_push_sum),
        .push_meta (w_push_meta),
        .pop       (out_valid && out_ready),
        .count     (w_count),
        .head_sum  (w_head_sum),
        .head_meta (w_head_meta)
    );

    assign out_valid = (w_count != '0);
    assign out_sum   = w_head_sum;
    assign out_len   = w_head_meta.len;
    assign out_ovf   = w_head_meta.ovf;

endmodule

// File: tb/tb_dot_acc.sv
// Directed bench for dot_acc: models the 2-edge multiplier and checks results,
// latency, flow control, reset and overflow for ACC_W=24 and ACC_W=16.
module tb_dot_acc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [7:0]  a = '0, b = '0;
    logic signed [7:0]  m_a = '0, m_b = '0;
    logic signed [15:0] prod = '0;

    logic               in_ready, out_valid, out_ovf;
    logic signed [23:0] out_sum;
    logic [7:0]         out_len;
    logic               in_ready16, out_valid16, out_ovf16;
    logic signed [15:0] out_sum16;
    logic [7:0]         out_len16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Multiplier model: operands registered at t, product at t+1.
    always @(posedge clk) begin
        m_a  <= a;
        m_b  <= b;
        prod <= m_a * m_b;
    end

    dot_acc #(.ACC_W(24), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .prod(prod), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_len(out_len), .out_ovf(out_ovf)
    );

    dot_acc #(.ACC_W(16), .DEPTH(2)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready16), .prod(prod), .out_valid(out_valid16),
        .out_ready(out_ready), .out_sum(out_sum16), .out_len(out_len16), .out_ovf(out_ovf16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [7:0] ta, input logic signed [7:0] tb_v, input logic last);
        int n;
        n = 0;
        a = ta;
        b = tb_v;
        in_last = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_wait: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic pop_head();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_sum !== 24'sd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", out_sum); end
        checks++; if (out_len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", out_len); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_vector4();
        for (int i = 0; i < 4; i++) beat(8'sd3, -8'sd5, i == 3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL v4_lat_e0: got %0b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL v4_lat_e1: got %0b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL v4_lat_e2: got %0b want 1", out_valid); end
        checks++; if (out_sum !== -24'sd60) begin errors++; $display("FAIL v4_sum: got %0d want -60", out_sum); end
        checks++; if (out_len !== 8'd4) begin errors++; $display("FAIL v4_len: got %0d want 4", out_len); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL v4_ovf: got %0b want 0", out_ovf); end
        pop_head();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL v4_pop: got %0b want 0", out_valid); end
    endtask

    task automatic test_single();
        beat(-8'sd128, -8'sd128, 1'b1);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
        checks++; if (out_sum !== 24'sd16384) begin errors++; $display("FAIL single_sum: got %0d want 16384", out_sum); end
        checks++; if (out_len !== 8'd1) begin errors++; $display("FAIL single_len: got %0d want 1", out_len); end
        pop_head();
    endtask

    task automatic test_back_to_back();
        logic signed [23:0] got [4];
        int  ngot;
        logic acc;
        ngot = 0;
        out_ready = 1'b0;
        beat(8'sd1, 8'sd5, 1'b1);
        beat(8'sd2, 8'sd3, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop: got %0b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold%0d: got %0b want 0", i, in_ready); end
        end
        checks++; if (out_sum !== 24'sd5) begin errors++; $display("FAIL b2b_head: got %0d want 5", out_sum); end
        // Release the consumer while a third last waits for credit.
        out_ready = 1'b1;
        a = 8'sd7;
        b = 8'sd7;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && ngot < 4) begin
                got[ngot] = out_sum;
                ngot++;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
        end
        out_ready = 1'b0;
        checks++; if (ngot !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ngot); end
        checks++; if (got[0] !== 24'sd5) begin errors++; $display("FAIL b2b_r0: got %0d want 5", got[0]); end
        checks++; if (got[1] !== 24'sd6) begin errors++; $display("FAIL b2b_r1: got %0d want 6", got[1]); end
        checks++; if (got[2] !== 24'sd49) begin errors++; $display("FAIL b2b_r2: got %0d want 49", got[2]); end
    endtask

    task automatic test_overflow();
        beat(-8'sd128, -8'sd128, 1'b0);
        beat(-8'sd128, -8'sd128, 1'b1);
        step(); step();
        checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL ovf16_valid: got %0b want 1", out_valid16); end
`ifdef DOT_ACC_SAT_EN
        checks++; if (out_sum16 !== 16'sh7FFF) begin errors++; $display("FAIL ovf16_sum: got %0d want 32767", out_sum16); end
`else
        checks++; if (out_sum16 !== 16'sh8000) begin errors++; $display("FAIL ovf16_sum: got %0d want -32768", out_sum16); end
`endif
        checks++; if (out_ovf16 !== 1'b1) begin errors++; $display("FAIL ovf16_flag: got %0b want 1", out_ovf16); end
        checks++; if (out_len16 !== 8'd2) begin errors++; $display("FAIL ovf16_len: got %0d want 2", out_len16); end
        checks++; if (out_sum !== 24'sd32768) begin errors++; $display("FAIL ovf24_sum: got %0d want 32768", out_sum); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf24_flag: got %0b want 0", out_ovf); end
        pop_head();
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        beat(8'sd1, 8'sd1, 1'b0);
        beat(8'sd1, 8'sd1, 1'b0);
        a = 8'sd1;
        b = 8'sd1;
        in_last = 1'b1;
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_out: got %0b want 0", seen); end
        beat(8'sd2, 8'sd2, 1'b1);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid: got %0b want 1", out_valid); end
        checks++; if (out_sum !== 24'sd4) begin errors++; $display("FAIL rstmid_sum: got %0d want 4", out_sum); end
        checks++; if (out_len !== 8'd1) begin errors++; $display("FAIL rstmid_len: got %0d want 1", out_len); end
        pop_head();
    endtask

    task automatic test_len_sat();
        for (int i = 0; i < 300; i++) beat(8'sd1, 8'sd1, i == 299);
        step(); step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len_valid: got %0b want 1", out_valid); end
        checks++; if (out_len !== 8'd255) begin errors++; $display("FAIL len_sat: got %0d want 255", out_len); end
        checks++; if (out_sum !== 24'sd300) begin errors++; $display("FAIL len_sum: got %0d want 300", out_sum); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL len_ovf: got %0b want 0", out_ovf); end
        checks++; if (out_sum16 !== 16'sd300) begin errors++; $display("FAIL len_sum16: got %0d want 300", out_sum16); end
        pop_head();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len_pop: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_vector4();
        test_single();
        test_back_to_back();
        step(); step();
        test_overflow();
        test_reset_mid();
        test_len_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
